// File: rtl/soc_it_message_send_engine.sv
// SoC-IT message send engine: buffers application beats in a FIFO and drives the
// request/ack, payload and completion handshake, one message in flight at a time.
`timescale 1ns/1ps
module soc_it_message_send_engine #(
    parameter int FIFO_DEPTH  = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         msg_in_valid,
    output logic         msg_in_ready,
    input  logic [127:0] msg_in_data,
    input  logic         msg_in_last,
    output logic         send_msg_request,
    input  logic         send_msg_ack,
    input  logic         send_msg_complete,
    input  logic [1:0]   send_msg_error,
    output logic         send_msg_src_rdy,
    input  logic         send_msg_dst_rdy,
    output logic [127:0] send_msg_payload,
    output logic         status_done,
    output logic [1:0]   status_error,
    output logic         status_timeout,
    output logic         busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        WAIT_CMPL,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [128:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W-1:0]   occ_next;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               head_last;
    logic [127:0]       head_data;

    assign fifo_empty         = (occ == '0);
    assign {head_last, head_data} = mem[rd_ptr];
    assign push               = msg_in_valid & msg_in_ready;
    assign send_msg_src_rdy   = (state == XFER) & ~fifo_empty;
    assign send_msg_payload   = send_msg_src_rdy ? head_data : '0;
    // In DRAIN the engine consumes beats itself, without the sink handshake.
    assign pop                = (send_msg_src_rdy & send_msg_dst_rdy) |
                                ((state == DRAIN) & ~fifo_empty);
    assign busy               = (state != IDLE);

    always_comb begin
        occ_next = occ;
        if (push && !pop)
            occ_next = occ + OCC_W'(1);
        else if (pop && !push)
            occ_next = occ - OCC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {msg_in_last, msg_in_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            msg_in_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            occ          <= occ_next;
            msg_in_ready <= (occ_next != OCC_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            cnt              <= '0;
            send_msg_request <= 1'b0;
            status_done      <= 1'b0;
            status_error     <= 2'd0;
            status_timeout   <= 1'b0;
        end else begin
            status_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!fifo_empty) begin
                        state            <= REQ;
                        send_msg_request <= 1'b1;
                    end
                end
                REQ: begin
                    if (cnt != CNT_MAX)
                        cnt <= cnt + CNT_W'(1);
                    // An ack in the final counted cycle still wins over the abort.
                    if (send_msg_ack) begin
                        state            <= XFER;
                        send_msg_request <= 1'b0;
                    end else if (cnt == CNT_LIMIT) begin
                        state            <= DRAIN;
                        send_msg_request <= 1'b0;
                    end
                end
                XFER: begin
                    if (pop && head_last)
                        state <= WAIT_CMPL;
                end
                WAIT_CMPL: begin
                    if (send_msg_complete) begin
                        status_error   <= send_msg_error;
                        status_timeout <= 1'b0;
                        status_done    <= 1'b1;
                        state          <= DONE;
                    end
                end
                DRAIN: begin
                    if (pop && head_last) begin
                        status_error   <= 2'd0;
                        status_timeout <= 1'b1;
                        status_done    <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A completion before the last payload beat is a sink protocol violation.
    complete_in_xfer: assert property (@(posedge clk) disable iff (!rst)
        !((state == XFER) && send_msg_complete));

endmodule
